fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 32: address/data width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter FLUSH_BUBBLES, default 1, legal range 0..7: extra bubble cycles after a flush.
REQ-004 clk  input  1: single clock, all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 stall  input  1: hazard hold from decode; the PC is not advanced.
REQ-007 branch_taken  input  1: decode-stage branch redirect request.
REQ-008 branch_target  input  N: redirect address paired with branch_taken.
REQ-009 flush  input  1: mispredict flush request.
REQ-010 flush_pc  input  N: recovery address paired with flush.
REQ-011 halt  input  1: stop fetching.
REQ-012 imem_ready  input  1: instruction memory returns data for pc this cycle.
REQ-013 pc  output  N: registered fetch address.
REQ-014 pc_plus4  output  N: combinational pc + 4, modulo 2^N.
REQ-015 fetch_req  output  1: instruction memory request for pc.
REQ-016 if_valid  output  1: IF/ID write enable; the fetched word is a valid instruction.
REQ-017 halted  output  1: high while in HALT.
REQ-018 redirect_cnt  output  16: count of accepted redirects.

Function
REQ-019 The FSM states SHALL be BOOT, RUN, MEMWAIT, BUBBLE and HALT; only pc, state, bubble counter, pending-redirect registers and redirect_cnt are stateful.
REQ-020 BOOT SHALL last exactly one cycle with fetch_req=0 and if_valid=0, then go to RUN with pc=RESET_PC.
REQ-021 RUN SHALL drive fetch_req=1 and apply the first true condition per cycle, in this priority order:
  - flush: pc<=flush_pc, if_valid=0; then BUBBLE if FLUSH_BUBBLES>0, else RUN.
  - branch_taken: pc<=branch_target, if_valid=0; stay in RUN.
  - halt: pc held, if_valid=0; go to HALT.
  - stall: pc held, if_valid=0.
  - ~imem_ready: pc held, if_valid=0; go to MEMWAIT.
  - otherwise: if_valid=1, pc<=pc+4.
REQ-022 MEMWAIT SHALL hold pc with fetch_req=1 and if_valid=0 until imem_ready=1.
REQ-023 A flush or branch_taken arriving in MEMWAIT SHALL be latched as a pending redirect; a later flush overwrites a pending branch, and a later branch never overwrites a pending flush.
REQ-024 On imem_ready in MEMWAIT with a pending redirect:
  - the returned word is discarded (if_valid=0);
  - pc loads the pending target and the pending register is cleared;
  - the next state follows the REQ-021 flush/branch rows.
REQ-025 On imem_ready in MEMWAIT with no pending redirect:
  - if stall=1: pc held, go to RUN;
  - otherwise: if_valid=1, pc<=pc+4, go to RUN.
REQ-026 BUBBLE SHALL drive fetch_req=0 and if_valid=0, load its counter with FLUSH_BUBBLES on entry, decrement once per cycle, and exit to RUN after exactly FLUSH_BUBBLES cycles.
REQ-027 In BUBBLE, flush SHALL reload pc=flush_pc and restart the counter; branch_taken, stall and halt SHALL be ignored.
REQ-028 HALT SHALL drive fetch_req=0, if_valid=0 and halted=1 with pc held.
REQ-029 HALT SHALL be left only by reset or by flush, which applies pc<=flush_pc and follows the REQ-021 flush path.
REQ-030 redirect_cnt SHALL increment by 1 in each cycle where pc loads flush_pc, branch_target or a pending target, and SHALL saturate at 16'hFFFF.
REQ-031 pc+4 SHALL wrap modulo 2^N, with no carry-out.
REQ-032 if_valid SHALL never be 1 in a cycle where pc does not advance by 4.

Reset
REQ-033 While rst_n=0, regardless of clk:
  - state=BOOT, pc=RESET_PC;
  - fetch_req=0, if_valid=0, halted=0;
  - redirect_cnt=0, bubble counter=0, pending redirect cleared.
REQ-034 Reset asserted in any state, including MEMWAIT with a pending redirect, SHALL discard all in-flight state.
REQ-035 The first fetch_req=1 SHALL occur in the second cycle after rst_n deasserts.

Verification
REQ-036 Reset release, imem_ready=1 throughout -> pc sequence 0,0,4,8,C; if_valid=0,1,1,1 from the RUN cycles onward.
REQ-037 In RUN at pc=8, flush=1 with flush_pc=40 and branch_taken=1 with branch_target=80 in the same cycle -> pc=40, one BUBBLE cycle, if_valid resumes at 40, redirect_cnt=1.
REQ-038 At pc=10, imem_ready=0 for 3 cycles, branch_taken=1 (target 100) in cycle 2 -> pc held at 10, then on ready the word is discarded, pc=100, redirect_cnt increments once.
REQ-039 stall=1 for 2 cycles at pc=20 -> pc=20 and if_valid=0 for 2 cycles, then 24.
REQ-040 halt=1 at pc=30 -> halted=1, fetch_req=0, pc=30 held; then flush with flush_pc=0 -> halted=0, pc=0.
REQ-041 N=32, pc=FFFFFFFC, normal fetch -> pc=00000000 with no error.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: control inputs from decode/IMEM and the fetch-side outputs.
// Handshake: fetch_req=1 asks instruction memory for the word at pc; the word is
// taken in any cycle where fetch_req=1 and imem_ready=1, and if_valid marks that
// the taken word is a real instruction for IF/ID (if_valid implies pc advances by 4).
interface fetch_ctrl_if #(
    parameter int N = 32
);
    logic         stall;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic         flush;
    logic [N-1:0] flush_pc;
    logic         halt;
    logic         imem_ready;

    logic [N-1:0] pc;
    logic [N-1:0] pc_plus4;
    logic         fetch_req;
    logic         if_valid;
    logic         halted;
    logic [15:0]  redirect_cnt;
    logic [2:0]   dbg_state;

    modport master (
        input  stall, branch_taken, branch_target, flush, flush_pc, halt, imem_ready,
        output pc, pc_plus4, fetch_req, if_valid, halted, redirect_cnt, dbg_state
    );

    modport slave (
        output stall, branch_taken, branch_target, flush, flush_pc, halt, imem_ready,
        input  pc, pc_plus4, fetch_req, if_valid, halted, redirect_cnt, dbg_state
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: sequential fetch, branch/flush redirects, memory wait
// with a pending-redirect latch, post-flush bubbles and halt.
module fetch_ctrl #(
    parameter int           N             = 32,
    parameter logic [N-1:0] RESET_PC      = '0,
    parameter int           FLUSH_BUBBLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master fc
);
    typedef enum logic [2:0] {
        S_BOOT    = 3'd0,
        S_RUN     = 3'd1,
        S_MEMWAIT = 3'd2,
        S_BUBBLE  = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    localparam logic [2:0]   BUB_LOAD = 3'(FLUSH_BUBBLES);
    localparam logic [N-1:0] FOUR     = {{(N-3){1'b0}}, 3'b100};

    state_e       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [2:0]   bub_q, bub_d;
    logic         pend_q, pend_d;
    logic         pend_flush_q, pend_flush_d;
    logic [N-1:0] pend_tgt_q, pend_tgt_d;
    logic [15:0]  rcnt_q, rcnt_d;

    logic         fetch_req, if_valid, halted;
    logic         redir, redir_flush;
    logic [N-1:0] redir_tgt;
    logic         eff_pend, eff_flush;
    logic [N-1:0] eff_tgt;
    logic [N-1:0] pc_plus4;

    // Increment wraps naturally at the register width.
    assign pc_plus4 = pc_q + FOUR;

    // State register; reset discards every in-flight redirect and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            bub_q        <= '0;
            pend_q       <= 1'b0;
            pend_flush_q <= 1'b0;
            pend_tgt_q   <= '0;
            rcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            bub_q        <= bub_d;
            pend_q       <= pend_d;
            pend_flush_q <= pend_flush_d;
            pend_tgt_q   <= pend_tgt_d;
            rcnt_q       <= rcnt_d;
        end
    end

    // Next-state and output decode; every redirect funnels through one common path.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        bub_d        = bub_q;
        pend_d       = pend_q;
        pend_flush_d = pend_flush_q;
        pend_tgt_d   = pend_tgt_q;
        rcnt_d       = rcnt_q;
        fetch_req    = 1'b0;
        if_valid     = 1'b0;
        halted       = 1'b0;
        redir        = 1'b0;
        redir_flush  = 1'b0;
        redir_tgt    = pc_q;
        eff_pend     = pend_q;
        eff_flush    = pend_flush_q;
        eff_tgt      = pend_tgt_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                pc_d    = RESET_PC;
            end
            S_RUN: begin
                fetch_req = 1'b1;
                if (fc.flush) begin
                    redir = 1'b1; redir_flush = 1'b1; redir_tgt = fc.flush_pc;
                end else if (fc.branch_taken) begin
                    redir = 1'b1; redir_tgt = fc.branch_target;
                end else if (fc.halt) begin
                    state_d = S_HALT;
                end else if (fc.stall) begin
                    state_d = S_RUN;
                end else if (!fc.imem_ready) begin
                    state_d = S_MEMWAIT;
                end else begin
                    if_valid = 1'b1;
                    pc_d     = pc_plus4;
                end
            end
            S_MEMWAIT: begin
                fetch_req = 1'b1;
                // A flush always wins; a branch never displaces a pending flush.
                if (fc.flush) begin
                    eff_pend = 1'b1; eff_flush = 1'b1; eff_tgt = fc.flush_pc;
                end else if (fc.branch_taken && !(pend_q && pend_flush_q)) begin
                    eff_pend = 1'b1; eff_flush = 1'b0; eff_tgt = fc.branch_target;
                end
                if (fc.imem_ready) begin
                    pend_d       = 1'b0;
                    pend_flush_d = 1'b0;
                    pend_tgt_d   = '0;
                    if (eff_pend) begin
                        redir = 1'b1; redir_flush = eff_flush; redir_tgt = eff_tgt;
                    end else begin
                        state_d = S_RUN;
                        if (!fc.stall) begin
                            if_valid = 1'b1;
                            pc_d     = pc_plus4;
                        end
                    end
                end else begin
                    pend_d       = eff_pend;
                    pend_flush_d = eff_flush;
                    pend_tgt_d   = eff_tgt;
                end
            end
            S_BUBBLE: begin
                if (fc.flush) begin
                    redir = 1'b1; redir_flush = 1'b1; redir_tgt = fc.flush_pc;
                end else if (bub_q <= 3'd1) begin
                    state_d = S_RUN;
                    bub_d   = '0;
                end else begin
                    bub_d = bub_q - 3'd1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (fc.flush) begin
                    redir = 1'b1; redir_flush = 1'b1; redir_tgt = fc.flush_pc;
                end
            end
            default: state_d = S_BOOT;
        endcase

        if (redir) begin
            pc_d = redir_tgt;
            if (redir_flush && (FLUSH_BUBBLES > 0)) begin
                state_d = S_BUBBLE;
                bub_d   = BUB_LOAD;
            end else begin
                state_d = S_RUN;
                bub_d   = '0;
            end
            if (rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
        end
    end

    assign fc.pc           = pc_q;
    assign fc.pc_plus4     = pc_plus4;
    assign fc.fetch_req    = fetch_req;
    assign fc.if_valid     = if_valid;
    assign fc.halted       = halted;
    assign fc.redirect_cnt = rcnt_q;
    assign fc.dbg_state    = state_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic, all checked
// against a behavioural model through an expected-output queue.
module tb_fetch_ctrl;
    localparam int FB = 1;
    localparam int W  = 83;

    logic clk;
    logic rst_n;

    fetch_ctrl_if #(.N(32)) bus ();

    fetch_ctrl #(.N(32), .RESET_PC(32'h0), .FLUSH_BUBBLES(FB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fc    (bus)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;

    // Behavioural model: what fetch is currently doing, expressed as flags and counts.
    logic [31:0] m_pc, m_pt, n_pc, n_pt;
    int m_rc, m_bub, m_pk, n_rc, n_bub, n_pk;   // m_pk: 0 none, 1 branch, 2 flush
    bit m_boot, m_halted, m_wait, n_boot, n_halted, n_wait;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [31:0] add4(logic [31:0] p);
        longint s;
        s = longint'(p) + 64'd4;
        return 32'(s % 64'h1_0000_0000);
    endfunction

    task automatic model_reset();
        m_boot = 1; m_pc = 32'h0; m_rc = 0; m_halted = 0; m_wait = 0;
        m_bub = 0; m_pk = 0; m_pt = 32'h0;
    endtask

    // Jump to a new fetch address; flushes are followed by the bubble window.
    task automatic take(input logic [31:0] tgt, input bit is_flush);
        n_pc = tgt;
        n_rc = (m_rc < 65535) ? m_rc + 1 : 65535;
        n_bub = is_flush ? FB : 0;
        n_halted = 0;
        n_wait = 0;
    endtask

    // Drive one cycle of inputs, push the expected outputs, then advance the model.
    task automatic cyc(input bit st, input bit br, input logic [31:0] bt,
                       input bit fl, input logic [31:0] fp, input bit hl, input bit rdy);
        bit ef, ev, eh;
        int kind;
        logic [31:0] tgt;
        bus.stall = st; bus.branch_taken = br; bus.branch_target = bt;
        bus.flush = fl; bus.flush_pc = fp; bus.halt = hl; bus.imem_ready = rdy;
        ef = 0; ev = 0; eh = 0;
        n_pc = m_pc; n_rc = m_rc; n_bub = m_bub; n_pk = m_pk; n_pt = m_pt;
        n_boot = m_boot; n_halted = m_halted; n_wait = m_wait;
        if (m_boot) begin
            n_boot = 0;
        end else if (m_halted) begin
            eh = 1;
            if (fl) take(fp, 1);
        end else if (m_bub > 0) begin
            if (fl) take(fp, 1);
            else n_bub = m_bub - 1;
        end else if (m_wait) begin
            ef = 1;
            kind = m_pk; tgt = m_pt;
            if (fl) begin kind = 2; tgt = fp; end
            else if (br && kind != 2) begin kind = 1; tgt = bt; end
            if (rdy) begin
                n_pk = 0; n_pt = 32'h0; n_wait = 0;
                if (kind != 0) take(tgt, kind == 2);
                else if (!st) begin ev = 1; n_pc = add4(m_pc); end
            end else begin
                n_pk = kind; n_pt = tgt;
            end
        end else begin
            ef = 1;
            if (fl) take(fp, 1);
            else if (br) take(bt, 0);
            else if (hl) n_halted = 1;
            else if (st) n_pc = m_pc;
            else if (!rdy) n_wait = 1;
            else begin ev = 1; n_pc = add4(m_pc); end
        end
        exp_q.push_back({m_pc, add4(m_pc), ef, ev, eh, m_rc[15:0]});
        @(posedge clk);
        #1;
        m_pc = n_pc; m_rc = n_rc; m_bub = n_bub; m_pk = n_pk; m_pt = n_pt;
        m_boot = n_boot; m_halted = n_halted; m_wait = n_wait;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 32'h0, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, bus.pc, 32'h0);
        chk({tag, "_fetch_req"}, {31'b0, bus.fetch_req}, 32'h0);
        chk({tag, "_if_valid"}, {31'b0, bus.if_valid}, 32'h0);
        chk({tag, "_halted"}, {31'b0, bus.halted}, 32'h0);
        chk({tag, "_redirect_cnt"}, {16'b0, bus.redirect_cnt}, 32'h0);
    endtask

    // Monitor: every cycle with an expectation queued, compare the DUT outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", bus.pc, e[82:51]);
            chk("pc_plus4", bus.pc_plus4, e[50:19]);
            chk("fetch_req", {31'b0, bus.fetch_req}, {31'b0, e[18]});
            chk("if_valid", {31'b0, bus.if_valid}, {31'b0, e[17]});
            chk("halted", {31'b0, bus.halted}, {31'b0, e[16]});
            chk("redirect_cnt", {16'b0, bus.redirect_cnt}, {16'b0, e[15:0]});
        end
    end

    // Stimulus: directed scenarios, mid-flight reset, then random traffic.
    initial begin
        rst_n = 1'b0;
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 32'h0;
        bus.flush = 0; bus.flush_pc = 32'h0; bus.halt = 0; bus.imem_ready = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Boot then sequential fetch 0,4 -> pc now 8.
        idle(3);
        chk("seq_pc8", bus.pc, 32'h8);
        // Flush beats a same-cycle branch.
        cyc(0, 1, 32'h80, 1, 32'h40, 0, 1);
        chk("flush_pc40", bus.pc, 32'h40);
        chk("flush_cnt1", {16'b0, bus.redirect_cnt}, 32'h1);
        idle(2);
        chk("after_bubble_pc44", bus.pc, 32'h44);

        // Memory wait with a branch arriving mid-wait.
        cyc(0, 0, 32'h0, 1, 32'h10, 0, 1);
        idle(1);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0);
        cyc(0, 1, 32'h100, 0, 32'h0, 0, 0);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("memwait_hold_pc10", bus.pc, 32'h10);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 1);
        chk("pending_pc100", bus.pc, 32'h100);
        chk("pending_cnt3", {16'b0, bus.redirect_cnt}, 32'h3);

        // Stall two cycles at 20.
        cyc(0, 0, 32'h0, 1, 32'h20, 0, 1);
        idle(1);
        cyc(1, 0, 32'h0, 0, 32'h0, 0, 1);
        cyc(1, 0, 32'h0, 0, 32'h0, 0, 1);
        chk("stall_pc20", bus.pc, 32'h20);
        idle(1);
        chk("stall_release_pc24", bus.pc, 32'h24);

        // Halt at 30, leave by flush to 0.
        cyc(0, 0, 32'h0, 1, 32'h30, 0, 1);
        idle(1);
        cyc(0, 0, 32'h0, 0, 32'h0, 1, 1);
        cyc(1, 1, 32'h200, 0, 32'h0, 1, 1);
        chk("halt_flag", {31'b0, bus.halted}, 32'h1);
        chk("halt_no_req", {31'b0, bus.fetch_req}, 32'h0);
        chk("halt_pc30", bus.pc, 32'h30);
        cyc(0, 0, 32'h0, 1, 32'h0, 0, 1);
        chk("unhalt_flag", {31'b0, bus.halted}, 32'h0);
        chk("unhalt_pc0", bus.pc, 32'h0);
        idle(1);

        // Wrap at the top of the address space.
        cyc(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 1);
        idle(2);
        chk("wrap_pc0", bus.pc, 32'h0);

        // Reset while waiting on memory with a pending flush.
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0);
        cyc(0, 0, 32'h0, 1, 32'h500, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        chk("midreset_pc4", bus.pc, 32'h4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 99) < 6, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75);
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
